multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control FSM for the single-datapath CPU. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the write/select strobes of the program counter, instruction register, register file, ALU and data memory. It also counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- opcode  in  6  instr[31:26] from instruction register; stable from DECODE through retire
- funct  in  6  instr[5:0]; same stability rule
- zero  in  1  ALU zero flag, combinational, valid in EXEC
- mem_ready  in  1  data-memory ready; used only with MEM_WAIT_EN
- ir_we  out  1  load instruction register
- pc_inc  out  1  PC <= PC+4
- pc_branch  out  1  PC <= PC+4+(sext(imm16)<<2)
- pc_jump  out  1  PC <= {PC[31:28], imm26, 2'b00}
- pc_jr  out  1  PC <= rs data
- alu_op  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- alu_src  out  1  0 = rt, 1 = sign-extended imm16
- reg_we  out  1  register-file write
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = link (PC+4)
- mem_re, mem_we  out  1 each  data-memory read / write
- illegal  out  1  sticky; unsupported opcode/funct
- state  out  3  current state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 7
- instr_count  out  CNT_W  retired-instruction count

## Operation
- Supported instructions:
  - R-type (opcode 000000) with funct ADD 100000, SUB 100010, SLT 101010, JR 001000.
  - LW 100011, SW 101011, BEQ 000100, BNE 000101, XORI 001110, J 000010, JAL 000011.
- FETCH: ir_we=1 -> DECODE.
- DECODE:
  - J: pc_jump, retire.
  - JAL: pc_jump, reg_we, reg_dst=2, wb_sel=2, retire.
  - JR: pc_jr, retire.
  - Illegal opcode/funct: set illegal, -> HALT.
  - Else -> EXEC.
- EXEC:
  - R-type: alu_op per funct, alu_src=0.
  - XORI: alu_op=XOR, alu_src=1.
  - LW/SW: alu_op=ADD, alu_src=1.
  - BEQ/BNE: alu_op=SUB, alu_src=0. pc_branch if (BEQ&zero)|(BNE&~zero), else pc_inc. Retire, -> FETCH.
  - R-type/XORI -> WB. LW/SW -> MEM.
- MEM:
  - LW: mem_re, -> WB.
  - SW: mem_we, pc_inc, retire, -> FETCH.
- WB: reg_we, pc_inc, retire, -> FETCH.
  - R-type: reg_dst=1, wb_sel=0.
  - XORI: reg_dst=0, wb_sel=0.
  - LW: reg_dst=0, wb_sel=1.
- alu_op and alu_src are held from EXEC through MEM/WB of the same instruction.
- Every retire cycle asserts exactly one of pc_inc/pc_branch/pc_jump/pc_jr, and instr_count increments on that edge.
- No other cycle asserts any PC strobe.
- HALT: all strobes 0, state held until rst. instr_count is frozen.
- instr_count wraps 2^CNT_W-1 -> 0.

## Timing
- While rst is high: state=FETCH, illegal=0, instr_count=0, all strobes 0.
- The first cycle after rst falls is FETCH with ir_we=1.
- rst mid-instruction aborts the instruction: no retire, no count.
- Strobes are combinational from state, opcode and funct (Moore, except the branch decision on zero). State changes on the rising edge.
- Latencies in cycles:
  - J/JAL/JR: 2.
  - BEQ/BNE: 3.
  - R-type/XORI/SW: 4.
  - LW: 5.

## Configuration
- MULTICYCLE_MEM_WAIT_EN defined:
  - MEM holds while mem_ready=0, with mem_re/mem_we held high.
  - SW asserts pc_inc and retires only in the cycle where mem_ready=1.
  - LW leaves MEM only when mem_ready=1.
- Undefined: MEM is always one cycle and mem_ready is ignored.

## Test plan
- rst for 2 cycles, then release -> state=0, ir_we=1 in the first cycle; instr_count=0.
- ADD (000000/100000) -> states 0,1,2,4. In WB: reg_we=1, reg_dst=1, pc_inc=1. instr_count=1.
- LW then SW -> 5 then 4 cycles. mem_re only in LW's MEM; mem_we+pc_inc only in SW's MEM. instr_count +2.
- BEQ with zero=1 -> pc_branch=1 in EXEC. BNE with zero=1 -> pc_inc=1, pc_branch=0. alu_op=001 in both.
- JAL -> in DECODE: pc_jump=1, reg_we=1, reg_dst=2, wb_sel=2. Next state FETCH.
- opcode 111111 -> illegal=1, state=7, no strobes for 10 cycles, count frozen. rst clears illegal. With MULTICYCLE_MEM_WAIT_EN: SW with mem_ready low for 3 cycles -> MEM held 4 cycles, pc_inc only in the last.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle control FSM for the single-datapath CPU. Sequences
//               each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
//               PC, IR, register-file, ALU and data-memory strobes, and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   opcode, funct   : instr[31:26] / instr[5:0] from the instruction register
//   zero            : ALU zero flag (branch decision in EXEC)
//   mem_ready       : data-memory ready (only with MULTICYCLE_MEM_WAIT_EN)
//   ir_we           : load instruction register
//   pc_inc/_branch/_jump/_jr : PC update selects (one-hot on retire)
//   alu_op, alu_src : ALU function (ADD/SUB/XOR/SLT) and B-operand select
//   reg_we, reg_dst, wb_sel : register-file write, destination, source
//   mem_re, mem_we  : data-memory read / write
//   illegal         : sticky unsupported-instruction flag
//   state           : current FSM state
//   instr_count     : retired-instruction counter (wraps)
// Configuration:
//   MULTICYCLE_MEM_WAIT_EN : when defined, MEM stalls until mem_ready=1.
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic             pc_jump,
    output logic             pc_jr,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             mem_re,
    output logic             mem_we,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    logic [2:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    // Instruction class decode
    logic w_is_rtype, w_is_alu_r, w_is_jr, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
    logic w_is_xori, w_is_j, w_is_jal, w_legal, w_mem_done, w_taken, w_retire;

    assign w_is_rtype = (opcode == OP_RTYPE);
    assign w_is_alu_r = w_is_rtype &&
                        (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
    assign w_is_jr    = w_is_rtype && (funct == FN_JR);
    assign w_is_lw    = (opcode == OP_LW);
    assign w_is_sw    = (opcode == OP_SW);
    assign w_is_beq   = (opcode == OP_BEQ);
    assign w_is_bne   = (opcode == OP_BNE);
    assign w_is_xori  = (opcode == OP_XORI);
    assign w_is_j     = (opcode == OP_J);
    assign w_is_jal   = (opcode == OP_JAL);
    assign w_legal    = w_is_alu_r | w_is_jr | w_is_lw | w_is_sw | w_is_beq |
                        w_is_bne | w_is_xori | w_is_j | w_is_jal;
    assign w_taken    = (w_is_beq & zero) | (w_is_bne & ~zero);

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign w_mem_done = mem_ready;
`else
    // MEM is single-cycle; mem_ready is deliberately ignored.
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_done = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ir_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        pc_jump   = 1'b0;
        pc_jr     = 1'b0;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;

        // ALU controls are a function of the instruction alone, so holding
        // them across EXEC/MEM/WB needs no extra storage: opcode/funct are
        // stable until retire.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            if (w_is_rtype) begin
                alu_src = 1'b0;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end else if (w_is_xori) begin
                alu_op  = ALU_XOR;
                alu_src = 1'b1;
            end else if (w_is_lw || w_is_sw) begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
            end else if (w_is_beq || w_is_bne) begin
                alu_op  = ALU_SUB;
                alu_src = 1'b0;
            end
        end

        case (state_q)
            ST_FETCH: begin
                ir_we   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!w_legal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (w_is_j) begin
                    pc_jump = 1'b1;
                    state_d = ST_FETCH;
                end else if (w_is_jal) begin
                    pc_jump = 1'b1;
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    wb_sel  = 2'd2;
                    state_d = ST_FETCH;
                end else if (w_is_jr) begin
                    pc_jr   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_beq || w_is_bne) begin
                    pc_branch = w_taken;
                    pc_inc    = ~w_taken;
                    state_d   = ST_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (w_is_lw) begin
                    mem_re = 1'b1;
                    if (w_mem_done) state_d = ST_WB;
                end else begin
                    mem_we = 1'b1;
                    if (w_mem_done) begin
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_inc  = 1'b1;
                reg_dst = w_is_rtype ? 2'd1 : 2'd0;
                wb_sel  = w_is_lw ? 2'd1 : 2'd0;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset forces every strobe low immediately, not just after the edge,
        // so an instruction in flight never retires.
        if (rst) begin
            ir_we     = 1'b0;
            pc_inc    = 1'b0;
            pc_branch = 1'b0;
            pc_jump   = 1'b0;
            pc_jr     = 1'b0;
            alu_op    = ALU_ADD;
            alu_src   = 1'b0;
            reg_we    = 1'b0;
            reg_dst   = 2'd0;
            wb_sel    = 2'd0;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
        end
    end

    // A cycle retires exactly when it selects a PC update.
    assign w_retire      = pc_inc | pc_branch | pc_jump | pc_jr;
    assign instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, w_retire};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = rst ? ST_FETCH : state_q;
    assign illegal     = illegal_q & ~rst;
    assign instr_count = rst ? '0 : instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        ir_we, pc_inc, pc_branch, pc_jump, pc_jr;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic        mem_re, mem_we;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instr_count;

    logic [7:0]  stb;
    int          checks;
    int          errors;
    int          exp_cnt;

    // {ir_we, pc_inc, pc_branch, pc_jump, pc_jr, reg_we, mem_re, mem_we}
    assign stb = {ir_we, pc_inc, pc_branch, pc_jump, pc_jr, reg_we, mem_re, mem_we};

    multicycle_control #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ir_we       (ir_we),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .pc_jump     (pc_jump),
        .pc_jr       (pc_jr),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .wb_sel      (wb_sel),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",   {29'd0, state},   32'd0);
        chk("rst_strobes", {24'd0, stb},     32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_count",   instr_count,      32'd0);

        // First cycle after release is FETCH
        rst = 1'b0;
        #1;
        chk("f0_state", {29'd0, state}, 32'd0);
        chk("f0_stb",   {24'd0, stb},   32'h80);
        chk("f0_count", instr_count,    32'd0);

        // ADD: FETCH, DECODE, EXEC, WB
        opcode = 6'b000000; funct = 6'b100000;
        cyc();
        chk("add_d_state", {29'd0, state}, 32'd1);
        chk("add_d_stb",   {24'd0, stb},   32'h00);
        cyc();
        chk("add_e_state", {29'd0, state}, 32'd2);
        chk("add_e_alu",   {28'd0, alu_op, alu_src}, {28'd0, 3'b000, 1'b0});
        chk("add_e_stb",   {24'd0, stb},   32'h00);
        cyc();
        chk("add_w_state", {29'd0, state}, 32'd4);
        chk("add_w_stb",   {24'd0, stb},   32'h44);
        chk("add_w_dst",   {28'd0, reg_dst, wb_sel}, {28'd0, 2'd1, 2'd0});
        chk("add_w_cnt",   instr_count,    32'd0);
        cyc();
        exp_cnt = 1;
        chk("add_f_state", {29'd0, state}, 32'd0);
        chk("add_f_cnt",   instr_count,    exp_cnt);

        // LW: 5 cycles
        opcode = 6'b100011;
        cyc();
        chk("lw_d_stb",   {24'd0, stb}, 32'h00);
        cyc();
        chk("lw_e_alu",   {28'd0, alu_op, alu_src}, {28'd0, 3'b000, 1'b1});
        cyc();
        chk("lw_m_state", {29'd0, state}, 32'd3);
        chk("lw_m_stb",   {24'd0, stb},   32'h02);
        cyc();
        chk("lw_w_state", {29'd0, state}, 32'd4);
        chk("lw_w_stb",   {24'd0, stb},   32'h44);
        chk("lw_w_dst",   {28'd0, reg_dst, wb_sel}, {28'd0, 2'd0, 2'd1});
        chk("lw_w_alu",   {28'd0, alu_op, alu_src}, {28'd0, 3'b000, 1'b1});
        cyc();
        exp_cnt++;
        chk("lw_f_cnt",   instr_count, exp_cnt);

        // SW: 4 cycles
        opcode = 6'b101011;
        cyc();
        cyc();
        chk("sw_e_stb",   {24'd0, stb},   32'h00);
        cyc();
        chk("sw_m_state", {29'd0, state}, 32'd3);
        chk("sw_m_stb",   {24'd0, stb},   32'h41);
        cyc();
        exp_cnt++;
        chk("sw_f_state", {29'd0, state}, 32'd0);
        chk("sw_f_cnt",   instr_count,    exp_cnt);

        // BEQ with zero=1: branch taken
        opcode = 6'b000100;
        cyc();
        cyc();
        zero = 1'b1;
        #1;
        chk("beq_e_stb", {24'd0, stb},    32'h20);
        chk("beq_e_alu", {29'd0, alu_op}, 32'd1);
        cyc();
        exp_cnt++;
        zero = 1'b0;
        chk("beq_f_state", {29'd0, state}, 32'd0);
        chk("beq_f_cnt",   instr_count,    exp_cnt);

        // BNE with zero=1: falls through
        opcode = 6'b000101;
        cyc();
        cyc();
        zero = 1'b1;
        #1;
        chk("bne_e_stb", {24'd0, stb},    32'h40);
        chk("bne_e_alu", {29'd0, alu_op}, 32'd1);
        zero = 1'b0;
        #1;
        chk("bne_nz_stb", {24'd0, stb},   32'h20);
        cyc();
        exp_cnt++;
        chk("bne_f_cnt", instr_count, exp_cnt);

        // XORI
        opcode = 6'b001110;
        cyc();
        cyc();
        chk("xori_e_alu", {28'd0, alu_op, alu_src}, {28'd0, 3'b010, 1'b1});
        cyc();
        chk("xori_w_stb", {24'd0, stb}, 32'h44);
        chk("xori_w_dst", {28'd0, reg_dst, wb_sel}, {28'd0, 2'd0, 2'd0});
        chk("xori_w_alu", {28'd0, alu_op, alu_src}, {28'd0, 3'b010, 1'b1});
        cyc();
        exp_cnt++;
        chk("xori_f_cnt", instr_count, exp_cnt);

        // SLT: alu_op 011
        opcode = 6'b000000; funct = 6'b101010;
        cyc();
        cyc();
        chk("slt_e_alu", {28'd0, alu_op, alu_src}, {28'd0, 3'b011, 1'b0});
        cyc();
        cyc();
        exp_cnt++;
        chk("slt_f_cnt", instr_count, exp_cnt);

        // JAL: retires in DECODE
        opcode = 6'b000011;
        cyc();
        chk("jal_d_stb", {24'd0, stb}, 32'h14);
        chk("jal_d_dst", {28'd0, reg_dst, wb_sel}, {28'd0, 2'd2, 2'd2});
        cyc();
        exp_cnt++;
        chk("jal_f_state", {29'd0, state}, 32'd0);
        chk("jal_f_cnt",   instr_count,    exp_cnt);

        // JR
        opcode = 6'b000000; funct = 6'b001000;
        cyc();
        chk("jr_d_stb", {24'd0, stb}, 32'h08);
        cyc();
        exp_cnt++;
        chk("jr_f_cnt", instr_count, exp_cnt);

`ifdef MULTICYCLE_MEM_WAIT_EN
        // SW with mem_ready low for 3 cycles: MEM held 4 cycles
        opcode = 6'b101011;
        mem_ready = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("swait_state", {29'd0, state}, 32'd3);
            chk("swait_stb",   {24'd0, stb},   32'h01);
        end
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("swait_last_state", {29'd0, state}, 32'd3);
        chk("swait_last_stb",   {24'd0, stb},   32'h41);
        cyc();
        exp_cnt++;
        chk("swait_f_cnt", instr_count, exp_cnt);
`endif

        // Illegal opcode: HALT, sticky flag, frozen count
        opcode = 6'b111111;
        cyc();
        chk("ill_d_state", {29'd0, state}, 32'd1);
        chk("ill_d_stb",   {24'd0, stb},   32'h00);
        cyc();
        chk("ill_h_state", {29'd0, state},   32'd7);
        chk("ill_h_flag",  {31'd0, illegal}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("halt_state", {29'd0, state}, 32'd7);
            chk("halt_stb",   {24'd0, stb},   32'h00);
            chk("halt_cnt",   instr_count,    exp_cnt);
        end

        // Reset clears HALT and the sticky flag
        rst = 1'b1;
        cyc();
        chk("clr_state",   {29'd0, state},   32'd0);
        chk("clr_illegal", {31'd0, illegal}, 32'd0);
        chk("clr_cnt",     instr_count,      32'd0);
        rst = 1'b0;
        #1;
        chk("clr_f_stb", {24'd0, stb}, 32'h80);

        // Reset during WB aborts the ADD: no retire, no count
        opcode = 6'b000000; funct = 6'b100000;
        cyc();
        cyc();
        cyc();
        chk("abort_w_state", {29'd0, state}, 32'd4);
        rst = 1'b1;
        #1;
        chk("abort_stb", {24'd0, stb}, 32'h00);
        cyc();
        chk("abort_cnt", instr_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_f_state", {29'd0, state}, 32'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("post_abort_cnt", instr_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
